fir3_out_serializer: RTL and testbench

//  Output-side adapter for the 3-parallel unfolded FIR_Filter: accepts one 3-sample

---
 rtl/fir3_out_serializer.sv | 120 ++++++++++++
 tb/tb_fir3_out_serializer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fir3_out_serializer.sv
// Block FIFO that takes one 3-sample FIR output block per clock and streams the
// samples out one per transfer (lane 0 first) over a valid/ready handshake.
module fir3_out_serializer #(
  parameter int unsigned NB    = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          vin_i,
  input  logic [NB-1:0] din0_i,
  input  logic [NB-1:0] din1_i,
  input  logic [NB-1:0] din2_i,
  input  logic          rdy_i,
  output logic          vout_o,
  output logic [NB-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          ovf_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = 3 * NB;

  typedef enum logic [1:0] {L0, L1, L2} lane_e;

  lane_e           lane_q, lane_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic [BW-1:0]   mem_q [DEPTH];

  logic            empty, full, xfer, pop, push;
  logic [BW-1:0]   head;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign xfer  = !empty && rdy_i;
  assign pop   = xfer && (lane_q == L2);
  assign push  = vin_i && (!full || pop);
  assign head  = mem_q[rd_ptr_q];

  // State register; the storage array is deliberately left out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lane_q   <= L0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      lane_q   <= lane_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {din2_i, din1_i, din0_i};
    end
  end

  // Lane FSM and FIFO bookkeeping; a full FIFO accepts only alongside a pop.
  always_comb begin
    lane_d   = lane_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (xfer) begin
      case (lane_q)
        L0:      lane_d = L1;
        L1:      lane_d = L2;
        L2:      lane_d = L0;
        default: lane_d = L0;
      endcase
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    if (vin_i && full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  // First-word fall-through output, driven from registered state only.
  always_comb begin
    dout_o = '0;
    if (!empty) begin
      case (lane_q)
        L0:      dout_o = head[NB-1:0];
        L1:      dout_o = head[2*NB-1:NB];
        L2:      dout_o = head[3*NB-1:2*NB];
        default: dout_o = '0;
      endcase
    end
  end

  assign vout_o  = !empty;
  assign empty_o = empty;
  assign full_o  = full;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_fir3_out_serializer.sv
// Directed bench for fir3_out_serializer: reset, single block, backpressure,
// overflow, push-with-pop while full, and reset mid-stream.
module tb_fir3_out_serializer;

  localparam int unsigned NB    = 12;
  localparam int unsigned DEPTH = 4;

  logic          clk, rst, vin, rdy;
  logic [NB-1:0] din0, din1, din2, dout;
  logic          vout, full, empty, ovf;

  int n_pass  = 0;
  int n_total = 0;

  fir3_out_serializer #(.NB(NB), .DEPTH(DEPTH)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .vin_i   (vin),
    .din0_i  (din0),
    .din1_i  (din1),
    .din2_i  (din2),
    .rdy_i   (rdy),
    .vout_o  (vout),
    .dout_o  (dout),
    .full_o  (full),
    .empty_o (empty),
    .ovf_o   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic [NB-1:0] a, input logic [NB-1:0] b, input logic [NB-1:0] c);
    vin  = 1'b1;
    din0 = a;
    din1 = b;
    din2 = c;
  endtask

  initial begin
    int pushed;
    rst = 1'b1; vin = 1'b0; rdy = 1'b0;
    din0 = '0; din1 = '0; din2 = '0;

    // Reset
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_vout", 32'(vout), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);

    // Single block with RDY high
    rdy = 1'b1;
    drive(12'd5, 12'hFFD, 12'h7FF);
    tick();
    vin = 1'b0;
    chk("single_vout", 32'(vout), 32'd1);
    chk("single_s0", 32'(dout), 32'h005);
    tick();
    chk("single_s1", 32'(dout), 32'hFFD);
    tick();
    chk("single_s2", 32'(dout), 32'h7FF);
    tick();
    chk("single_empty", 32'(empty), 32'd1);
    chk("single_vout0", 32'(vout), 32'd0);
    chk("single_dout0", 32'(dout), 32'd0);

    // Backpressure: outputs hold while RDY=0
    rdy = 1'b0;
    drive(12'd11, 12'd22, 12'd33);
    tick();
    vin = 1'b0;
    chk("bp_vout", 32'(vout), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_hold", 32'(dout), 32'd11);
    end
    rdy = 1'b1;
    tick();
    chk("bp_s1", 32'(dout), 32'd22);
    tick();
    chk("bp_s2", 32'(dout), 32'd33);
    tick();
    chk("bp_empty", 32'(empty), 32'd1);

    // Fill to full, fifth block dropped
    rdy = 1'b0;
    for (int b = 1; b <= 5; b++) begin
      drive(12'(b * 16), 12'(b * 16 + 1), 12'(b * 16 + 2));
      tick();
      if (b == 3) chk("fill_notfull", 32'(full), 32'd0);
      if (b == 4) begin
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_noovf", 32'(ovf), 32'd0);
      end
    end
    vin = 1'b0;
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_full", 32'(full), 32'd1);
    rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk("drain", 32'(dout), 32'((i / 3 + 1) * 16 + i % 3));
      tick();
    end
    chk("drain_empty", 32'(empty), 32'd1);
    chk("ovf_sticky", 32'(ovf), 32'd1);

    // Push while full with concurrent pop; 20 blocks, sample n has value 100+n
    rdy = 1'b0;
    pushed = 0;
    for (int b = 0; b < 4; b++) begin
      drive(12'(100 + 3 * b), 12'(101 + 3 * b), 12'(102 + 3 * b));
      tick();
      pushed++;
    end
    vin = 1'b0;
    chk("wrap_full", 32'(full), 32'd1);
    rdy = 1'b1;
    for (int k = 0; k < 60; k++) begin
      logic did_push;
      did_push = 1'b0;
      chk("wrap_order", 32'(dout), 32'(100 + k));
      if (k % 3 == 2 && pushed < 20) begin
        drive(12'(100 + 3 * pushed), 12'(101 + 3 * pushed), 12'(102 + 3 * pushed));
        did_push = 1'b1;
        pushed++;
      end
      tick();
      vin = 1'b0;
      if (did_push) begin
        chk("wrap_keepfull", 32'(full), 32'd1);
        chk("wrap_ovf", 32'(ovf), 32'd1);
      end
    end
    chk("wrap_empty", 32'(empty), 32'd1);

    // Reset mid-stream with lane L1 and 3 blocks stored
    rdy = 1'b0;
    for (int b = 0; b < 3; b++) begin
      drive(12'(200 + 3 * b), 12'(201 + 3 * b), 12'(202 + 3 * b));
      tick();
    end
    vin = 1'b0;
    rdy = 1'b1;
    tick();
    chk("mid_lane1", 32'(dout), 32'd201);
    rdy = 1'b0;
    rst = 1'b1;
    #1;
    chk("mid_vout", 32'(vout), 32'd0);
    chk("mid_empty", 32'(empty), 32'd1);
    chk("mid_dout", 32'(dout), 32'd0);
    chk("mid_ovf", 32'(ovf), 32'd0);
    tick();
    rst = 1'b0;
    rdy = 1'b1;
    drive(12'd300, 12'd301, 12'd302);
    tick();
    vin = 1'b0;
    chk("post_s0", 32'(dout), 32'd300);
    tick();
    chk("post_s1", 32'(dout), 32'd301);
    tick();
    chk("post_s2", 32'(dout), 32'd302);
    tick();
    chk("post_empty", 32'(empty), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
